// File: rtl/minilab_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : minilab_pkg
//  Description : Shared sizes and the operand-loader state type for the
//                matrix-multiply mini-lab.
//  Revision    : 1.0 - initial release
// ============================================================================
package minilab_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ROWS       = 8;
    localparam int WORD_WIDTH = ROWS * DATA_WIDTH;
    localparam int B_IDX      = ROWS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } fill_state_t;

endpackage : minilab_pkg
`default_nettype wire

// File: rtl/byte_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : byte_unpacker
//  Description : Holds one memory word and hands it out one element at a
//                time, low element first.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_unpacker #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int WORD_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [WORD_WIDTH-1:0] word_i,
    input  logic                  advance_i,
    output logic [DATA_WIDTH-1:0] byte_o,
    output logic                  last_o
);

    localparam int CNT_W = $clog2(ROWS);

    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bcnt_q,  bcnt_d;

    assign byte_o = shreg_q[DATA_WIDTH-1:0];
    assign last_o = (bcnt_q == CNT_W'(ROWS - 1));

    // Load a fresh word, or drop the element just consumed; the counter
    // returns to zero after the last element so it never wraps mid-word.
    always_comb begin
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        if (load_i) begin
            shreg_d = word_i;
            bcnt_d  = '0;
        end else if (advance_i) begin
            shreg_d = shreg_q >> DATA_WIDTH;
            bcnt_d  = last_o ? '0 : bcnt_q + CNT_W'(1);
        end
    end

    // Unpack register and element counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            bcnt_q  <= '0;
        end else begin
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
        end
    end

endmodule : byte_unpacker
`default_nettype wire

// File: rtl/fifo_filler.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_filler
//  Description : Avalon-MM read master that fetches the eight A rows and the
//                B vector and streams them byte by byte into the operand
//                FIFOs of the matrix-multiply unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_filler #(
    parameter int DATA_WIDTH = minilab_pkg::DATA_WIDTH,
    parameter int ROWS       = minilab_pkg::ROWS,
    parameter int WORD_WIDTH = minilab_pkg::WORD_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  read,
    input  logic                  waitrequest,
    input  logic [WORD_WIDTH-1:0] readdata,
    input  logic                  readdatavalid,
    input  logic [ROWS:0]         fifo_full,
    output logic [ROWS:0]         fifo_wren,
    output logic [DATA_WIDTH-1:0] fifo_data
);

    import minilab_pkg::*;

    localparam int IDX_W = 4;

    fill_state_t           state_q, state_d;
    logic [IDX_W-1:0]      idx_q,   idx_d;
    logic [ROWS:0]         wren_q,  wren_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;

    logic                  unp_load;
    logic                  unp_advance;
    logic [DATA_WIDTH-1:0] unp_byte;
    logic                  unp_last;
    logic                  tgt_full;
    logic                  read_c;

    // Full flag of the FIFO currently being filled (index ROWS is B).
    assign tgt_full  = fifo_full[idx_q];

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign read      = read_c;
    assign address   = {{(ADDR_WIDTH - IDX_W){1'b0}}, idx_q};
    assign fifo_wren = wren_q;
    assign fifo_data = data_q;

    byte_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROWS       (ROWS),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_unpacker (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (unp_load),
        .word_i     (readdata),
        .advance_i  (unp_advance),
        .byte_o     (unp_byte),
        .last_o     (unp_last)
    );

    // Next-state, row index and registered FIFO-write decode; clr overrides
    // everything so nothing from an aborted transfer reaches the FIFOs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wren_d      = '0;
        data_d      = data_q;
        unp_load    = 1'b0;
        unp_advance = 1'b0;
        read_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                read_c = 1'b1;
                if (!waitrequest) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (readdatavalid) begin
                    unp_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (!tgt_full) begin
                    unp_advance = 1'b1;
                    wren_d      = (ROWS + 1)'(1) << idx_q;
                    data_d      = unp_byte;
                    if (unp_last) begin
                        if (idx_q == IDX_W'(ROWS)) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = REQ;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr) begin
            state_d     = IDLE;
            wren_d      = '0;
            unp_load    = 1'b0;
            unp_advance = 1'b0;
        end
    end

    // State, row index and the registered FIFO write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wren_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wren_q  <= wren_d;
            data_q  <= data_d;
        end
    end

endmodule : fifo_filler
`default_nettype wire

// File: tb/tb_fifo_filler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_filler
//  Description : Directed self-checking bench for fifo_filler with a small
//                Avalon memory model and per-FIFO byte scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_filler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        clr;
    logic        busy;
    logic        done;
    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic [8:0]  fifo_full;
    logic [8:0]  fifo_wren;
    logic [7:0]  fifo_data;

    int vectors     = 0;
    int miscompares = 0;

    // memory / FIFO model controls
    logic        lat2  = 1'b0;
    logic        ws_en = 1'b0;
    logic        bp_en = 1'b0;
    int          ws_left    = 3;
    int          full2_left = 0;
    int          wr2_cnt    = 0;
    logic [1:0]  rdv_pipe   = 2'b00;
    logic [63:0] d_pipe0    = '0;
    logic [63:0] d_pipe1    = '0;

    // scoreboard
    logic        sb_clr = 1'b0;
    logic [7:0]  fq [0:8][$];
    logic [31:0] aq [$];
    int          onehot_viol  = 0;
    int          done_cnt     = 0;
    int          stall_cycles = 0;
    int          stall_bad    = 0;
    int          bp_viol      = 0;
    logic        full2_prev   = 1'b0;

    fifo_filler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .clr           (clr),
        .busy          (busy),
        .done          (done),
        .address       (address),
        .read          (read),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .fifo_full     (fifo_full),
        .fifo_wren     (fifo_wren),
        .fifo_data     (fifo_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        if (a == 32'd8) return 64'h0807060504030201;
        return {8{b}};
    endfunction

    assign waitrequest   = ws_en && read && (address == 32'd4) && (ws_left > 0);
    assign readdatavalid = lat2 ? rdv_pipe[1] : rdv_pipe[0];
    assign readdata      = lat2 ? d_pipe1 : d_pipe0;
    assign fifo_full     = {6'b0, (full2_left > 0), 2'b0};

    // Memory with latency 1 or 2, waitrequest on address 4, and a 5-cycle
    // full window on FIFO 2 opened after its third byte.
    always @(posedge clk) begin
        rdv_pipe <= {rdv_pipe[0], read && !waitrequest};
        d_pipe0  <= mem_word(address);
        d_pipe1  <= d_pipe0;
        if (!ws_en) ws_left <= 3;
        else if (read && address == 32'd4 && ws_left > 0) ws_left <= ws_left - 1;
        if (!bp_en) begin
            wr2_cnt    <= 0;
            full2_left <= 0;
        end else begin
            if (fifo_wren[2]) wr2_cnt <= wr2_cnt + 1;
            if (fifo_wren[2] && wr2_cnt == 2) full2_left <= 5;
            else if (full2_left > 0) full2_left <= full2_left - 1;
        end
    end

    // Mid-cycle monitor: records FIFO bytes, accepted addresses, stalls.
    always @(negedge clk) begin
        if (sb_clr) begin
            for (int k = 0; k < 9; k++) fq[k].delete();
            aq.delete();
            onehot_viol  = 0;
            done_cnt     = 0;
            stall_cycles = 0;
            stall_bad    = 0;
            bp_viol      = 0;
        end else begin
            if (fifo_wren != 9'd0) begin
                if (!$onehot(fifo_wren)) onehot_viol++;
                for (int k = 0; k < 9; k++)
                    if (fifo_wren[k]) fq[k].push_back(fifo_data);
            end
            if (read && !waitrequest) aq.push_back(address);
            if (read && waitrequest) begin
                stall_cycles++;
                if (address != 32'd4) stall_bad++;
            end
            if (done) done_cnt++;
            if (fifo_wren[2] && full2_prev) bp_viol++;
        end
        full2_prev = fifo_full[2];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        sb_clr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sb_clr = 1'b0;
    endtask

    // Start a load; optionally pulse start again at cycle restart_at.
    task automatic run_load(input int restart_at, output int n);
        @(negedge clk);
        start = 1'b1;
        n     = 0;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            start = (n == restart_at);
        end
        start = 1'b0;
    endtask

    task automatic check_contents(input string pre);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("%s_f%0d_count", pre, k), 64'(fq[k].size()), 64'd8);
            for (int j = 0; j < 8 && j < fq[k].size(); j++)
                check($sformatf("%s_f%0d_b%0d", pre, k, j), 64'(fq[k][j]),
                      (k < 8) ? 64'(k) : 64'(j + 1));
        end
        check({pre, "_onehot"}, 64'(onehot_viol), 64'd0);
    endtask

    task automatic check_addrs(input string pre);
        check({pre, "_naddr"}, 64'(aq.size()), 64'd9);
        for (int i = 0; i < 9 && i < aq.size(); i++)
            check($sformatf("%s_addr%0d", pre, i), 64'(aq[i]), 64'(i));
    endtask

    task automatic check_outputs_zero(input string pre);
        check({pre, "_busy"},  64'(busy),      64'd0);
        check({pre, "_done"},  64'(done),      64'd0);
        check({pre, "_read"},  64'(read),      64'd0);
        check({pre, "_addr"},  64'(address),   64'd0);
        check({pre, "_wren"},  64'(fifo_wren), 64'd0);
        check({pre, "_fdata"}, 64'(fifo_data), 64'd0);
    endtask

    initial begin
        int   n;
        logic found;

        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        clear_sb();

        // basic load, L=1
        run_load(0, n);
        check("basic_cycles", 64'(n), 64'd91);
        check("basic_done_pulse", 64'(done), 64'd1);
        check("basic_busy_at_done", 64'(busy), 64'd1);
        @(negedge clk);
        check("basic_done_fall", 64'(done), 64'd0);
        check("basic_busy_fall", 64'(busy), 64'd0);
        check("basic_done_count", 64'(done_cnt), 64'd1);
        check_contents("basic");
        check_addrs("basic");
        clear_sb();

        // waitrequest held 3 cycles on address 4
        ws_en = 1'b1;
        run_load(0, n);
        check("stall_cycles_total", 64'(n), 64'd94);
        check("stall_wr_cycles", 64'(stall_cycles), 64'd3);
        check("stall_addr_held", 64'(stall_bad), 64'd0);
        @(negedge clk);
        check_contents("stall");
        check_addrs("stall");
        ws_en = 1'b0;
        clear_sb();

        // FIFO 2 full for 5 cycles mid-row
        bp_en = 1'b1;
        run_load(0, n);
        check("bp_cycles_total", 64'(n), 64'd96);
        @(negedge clk);
        check("bp_write_while_full", 64'(bp_viol), 64'd0);
        check_contents("bp");
        bp_en = 1'b0;
        clear_sb();

        // abort during WAIT of row 3, data arrives the cycle after clr
        lat2 = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (read && !waitrequest && address == 32'd3) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_reached_row3", 64'(found), 64'd1);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_read", 64'(read), 64'd0);
        check("abort_wren", 64'(fifo_wren), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (15) @(negedge clk);
        check("abort_f3_writes", 64'(fq[3].size()), 64'd0);
        check("abort_f2_writes", 64'(fq[2].size()), 64'd8);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);
        lat2 = 1'b0;
        clear_sb();
        run_load(0, n);
        check("reload_cycles", 64'(n), 64'd91);
        @(negedge clk);
        check_addrs("reload");
        check_contents("reload");
        clear_sb();

        // start pulsed while busy is ignored
        run_load(20, n);
        check("ignstart_cycles", 64'(n), 64'd91);
        @(negedge clk);
        check_addrs("ignstart");
        check("ignstart_done_count", 64'(done_cnt), 64'd1);
        clear_sb();

        // asynchronous reset during row 1 SHIFT
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (fifo_wren[1]) found = 1'b1;
            else @(negedge clk);
        end
        check("rst_reached_row1", 64'(found), 64'd1);
        check("rst_pre_busy", 64'(busy), 64'd1);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_stays_idle", 64'(busy), 64'd0);
        check("midrst_no_done", 64'(done_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fifo_filler
`default_nettype wire
